// File: rtl/mix_tree_pkg.sv
// Shared types and helpers for the mixer-tree dispense sequencer.
// MIX_TREE_FLUSH_EN adds the FLUSH state to the state type.
package mix_tree_pkg;

    localparam int MAX_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MIX   = 3'd2,
        ST_DRAIN = 3'd3,
`ifdef MIX_TREE_FLUSH_EN
        ST_FLUSH = 3'd5,
`endif
        ST_DONE  = 3'd4
    } state_e;

    // Heap order: level l occupies bits 2^l-1 .. 2^(l+1)-2.
    function automatic logic [MAX_BITS-1:0] level_mask(input int level);
        logic [MAX_BITS-1:0] ones;
        ones = (MAX_BITS'(1) << (1 << level)) - MAX_BITS'(1);
        return ones << ((1 << level) - 1);
    endfunction

    // Lowest set bit at or above 'from'; MAX_BITS when none remain.
    function automatic int next_set_index(input logic [MAX_BITS-1:0] mask, input int from);
        int idx;
        idx = MAX_BITS;
        for (int i = MAX_BITS - 1; i >= 0; i--) begin
            if (i >= from && mask[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/mix_tree_dispense_ctrl_if.sv
// Host handshake and valve/mixer drive bundle of the dispense sequencer.
// No configuration macros affect this file.
interface mix_tree_dispense_ctrl_if #(parameter int LEVELS = 2);

    localparam int N_INPUTS = 2 ** LEVELS;
    localparam int N_MIXERS = N_INPUTS - 1;

    logic                start;
    logic                abort;
    logic [N_INPUTS-1:0] load_mask;
    logic [N_INPUTS-1:0] inlet_valve;
    logic [N_MIXERS-1:0] mix_en;
    logic                outlet_valve;
    logic                busy;
    logic                done;

    modport master (
        output start, abort, load_mask,
        input  inlet_valve, mix_en, outlet_valve, busy, done
    );

    modport slave (
        input  start, abort, load_mask,
        output inlet_valve, mix_en, outlet_valve, busy, done
    );

endinterface

// File: rtl/mix_tree_phase_timer.sv
// Loadable down-counter timing each sequencer phase; last_o marks its final cycle.
// No configuration macros affect this file.
module mix_tree_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         last_o
);

    logic [W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset is synchronous, checked inside the clocked block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q > W'(1)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign last_o = (count_q == W'(1));

endmodule

// File: rtl/mix_tree_dispense_ctrl.sv
// Dispense-mix-drain sequencer for the binary mixer tree, all outputs registered.
// Define MIX_TREE_FLUSH_EN to add a FLUSH rinse phase between DRAIN and DONE.
module mix_tree_dispense_ctrl
    import mix_tree_pkg::*;
#(
    parameter int LEVELS       = 2,
    parameter int LOAD_CYCLES  = 3,
    parameter int MIX_CYCLES   = 5,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mix_tree_dispense_ctrl_if.slave bus
);

    localparam int N_INPUTS = 2 ** LEVELS;
    localparam int N_MIXERS = N_INPUTS - 1;
    localparam int MAX_CYC  = (LOAD_CYCLES > MIX_CYCLES)
                            ? ((LOAD_CYCLES > DRAIN_CYCLES) ? LOAD_CYCLES : DRAIN_CYCLES)
                            : ((MIX_CYCLES  > DRAIN_CYCLES) ? MIX_CYCLES  : DRAIN_CYCLES);
    localparam int TW = $clog2(MAX_CYC + 1);
    localparam int IW = (LEVELS > 0) ? LEVELS : 1;
    localparam int LW = (LEVELS > 1) ? $clog2(LEVELS) : 1;

    localparam logic [TW-1:0] LOAD_VAL  = TW'(LOAD_CYCLES);
    localparam logic [TW-1:0] MIX_VAL   = TW'(MIX_CYCLES);
    localparam logic [TW-1:0] DRAIN_VAL = TW'(DRAIN_CYCLES);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [LW-1:0]       level_q, level_d;
    logic [N_INPUTS-1:0] mask_q, mask_d;
    logic                t_load, t_last;
    logic [TW-1:0]       t_val;
    int                  first_idx, next_idx;

    logic [N_INPUTS-1:0] inlet_q, inlet_d;
    logic [N_MIXERS-1:0] mix_q, mix_d;
    logic                outlet_q, outlet_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    mix_tree_phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (t_load),
        .load_val_i (t_val),
        .last_o     (t_last)
    );

    always_comb begin
        first_idx = next_set_index(MAX_BITS'(bus.load_mask), 0);
        next_idx  = next_set_index(MAX_BITS'(mask_q), int'(idx_q) + 1);
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        level_d = level_q;
        mask_d  = mask_q;
        t_load  = 1'b0;
        t_val   = '0;
        if (bus.abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && (bus.load_mask != '0)) begin
                        mask_d  = bus.load_mask;
                        idx_d   = IW'(first_idx);
                        state_d = ST_LOAD;
                        t_load  = 1'b1;
                        t_val   = LOAD_VAL;
                    end
                end
                ST_LOAD: begin
                    if (t_last) begin
                        t_load = 1'b1;
                        if (next_idx < N_INPUTS) begin
                            idx_d = IW'(next_idx);
                            t_val = LOAD_VAL;
                        end else begin
                            state_d = ST_MIX;
                            level_d = LW'(LEVELS - 1);
                            t_val   = MIX_VAL;
                        end
                    end
                end
                ST_MIX: begin
                    if (t_last) begin
                        t_load = 1'b1;
                        if (level_q == '0) begin
                            state_d = ST_DRAIN;
                            t_val   = DRAIN_VAL;
                        end else begin
                            level_d = level_q - LW'(1);
                            t_val   = MIX_VAL;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (t_last) begin
`ifdef MIX_TREE_FLUSH_EN
                        state_d = ST_FLUSH;
                        t_load  = 1'b1;
                        t_val   = DRAIN_VAL;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
`ifdef MIX_TREE_FLUSH_EN
                ST_FLUSH: begin
                    if (t_last) state_d = ST_DONE;
                end
`endif
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear on the same edge.
    always_comb begin
        inlet_d  = '0;
        mix_d    = '0;
        outlet_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        case (state_d)
            ST_LOAD: begin
                inlet_d = N_INPUTS'(1) << idx_d;
                busy_d  = 1'b1;
            end
            ST_MIX: begin
                mix_d  = N_MIXERS'(level_mask(int'(level_d)));
                busy_d = 1'b1;
            end
            ST_DRAIN: begin
                outlet_d = 1'b1;
                busy_d   = 1'b1;
            end
`ifdef MIX_TREE_FLUSH_EN
            // Rinse: everything open at once, the run is still in progress.
            ST_FLUSH: begin
                inlet_d  = '1;
                mix_d    = '1;
                outlet_d = 1'b1;
                busy_d   = 1'b1;
            end
`endif
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            level_q  <= '0;
            mask_q   <= '0;
            inlet_q  <= '0;
            mix_q    <= '0;
            outlet_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            level_q  <= level_d;
            mask_q   <= mask_d;
            inlet_q  <= inlet_d;
            mix_q    <= mix_d;
            outlet_q <= outlet_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.inlet_valve  = inlet_q;
    assign bus.mix_en       = mix_q;
    assign bus.outlet_valve = outlet_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_mix_tree_dispense_ctrl.sv
// Self-checking bench for mix_tree_dispense_ctrl with a cycle-trace reference model.
// Compile with MIX_TREE_FLUSH_EN to expect the FLUSH phase as well.
module tb_mix_tree_dispense_ctrl;

    localparam int LEVELS = 2;
    localparam int LC     = 3;
    localparam int MC     = 5;
    localparam int DC     = 2;

    typedef struct packed {
        logic [3:0] inlet;
        logic [2:0] mix;
        logic       outlet;
        logic       busy;
        logic       done;
    } obs_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    obs_t exp_q[$];

    mix_tree_dispense_ctrl_if #(.LEVELS(LEVELS)) bus ();

    mix_tree_dispense_ctrl #(
        .LEVELS       (LEVELS),
        .LOAD_CYCLES  (LC),
        .MIX_CYCLES   (MC),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(logic [3:0] i, logic [2:0] m, logic o, logic b, logic d);
        obs_t r;
        r.inlet = i; r.mix = m; r.outlet = o; r.busy = b; r.done = d;
        return r;
    endfunction

    function automatic obs_t get_obs();
        return mk(bus.inlet_valve, bus.mix_en, bus.outlet_valve, bus.busy, bus.done);
    endfunction

    // Mixers of each tree level: root alone is level 0, its two children level 1.
    function automatic logic [2:0] lvl_bits(int l);
        case (l)
            0:       return 3'b001;
            1:       return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    // Expected per-cycle outputs of one run, starting with the start edge, plus the idle cycle after done.
    function automatic void push_run(logic [3:0] mask);
        for (int i = 0; i < 4; i++)
            if (mask[i]) repeat (LC) exp_q.push_back(mk(4'b0001 << i, 3'b000, 1'b0, 1'b1, 1'b0));
        for (int l = LEVELS - 1; l >= 0; l--)
            repeat (MC) exp_q.push_back(mk(4'b0000, lvl_bits(l), 1'b0, 1'b1, 1'b0));
        repeat (DC) exp_q.push_back(mk(4'b0000, 3'b000, 1'b1, 1'b1, 1'b0));
`ifdef MIX_TREE_FLUSH_EN
        repeat (DC) exp_q.push_back(mk(4'b1111, 3'b111, 1'b1, 1'b1, 1'b0));
`endif
        exp_q.push_back(mk(4'b0000, 3'b000, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(4'b0000, 3'b000, 1'b0, 1'b0, 1'b0));
    endfunction

    task automatic start_run(input logic [3:0] mask, input bit hold);
        bus.start     = 1'b1;
        bus.load_mask = mask;
        @(posedge clk); #1;
        if (!hold) bus.start = 1'b0;
        bus.load_mask = 4'($urandom);
    endtask

    task automatic test_reset();
        obs_t got;
        rst_n = 1'b0; bus.start = 1'b1; bus.abort = 1'b0; bus.load_mask = 4'b1111;
        repeat (2) begin
            @(posedge clk); #1;
            got = get_obs(); n_cmp++;
            if (got !== '0) begin n_bad++; $display("FAIL reset got %b want %b", got, obs_t'('0)); end
        end
        rst_n = 1'b1; bus.start = 1'b0;
        @(posedge clk); #1;
        got = get_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL reset_idle got %b want %b", got, obs_t'('0)); end
    endtask

    task automatic test_full_mask();
        obs_t got;
        exp_q.delete(); push_run(4'b1111);
        start_run(4'b1111, 1'b0);
        foreach (exp_q[k]) begin
            got = get_obs(); n_cmp++;
            if (got !== exp_q[k]) begin n_bad++; $display("FAIL full_mask E%0d got %b want %b", k, got, exp_q[k]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sparse_mask();
        obs_t got;
        exp_q.delete(); push_run(4'b0101);
        start_run(4'b0101, 1'b0);
        foreach (exp_q[k]) begin
            got = get_obs(); n_cmp++;
            if (got !== exp_q[k]) begin n_bad++; $display("FAIL sparse_mask E%0d got %b want %b", k, got, exp_q[k]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_zero_mask();
        obs_t got;
        bus.start = 1'b1; bus.load_mask = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            got = get_obs(); n_cmp++;
            if (got !== '0) begin n_bad++; $display("FAIL zero_mask cyc%0d got %b want %b", k, got, obs_t'('0)); end
        end
        bus.load_mask = 4'b1111; bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.abort = 1'b0;
        got = get_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL abort_beats_start got %b want %b", got, obs_t'('0)); end
        @(posedge clk); #1;
        got = get_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL abort_beats_start_after got %b want %b", got, obs_t'('0)); end
    endtask

    task automatic test_abort();
        obs_t got;
        exp_q.delete(); push_run(4'b1111);
        start_run(4'b1111, 1'b0);
        for (int k = 0; k <= 14; k++) begin
            got = get_obs(); n_cmp++;
            if (got !== exp_q[k]) begin n_bad++; $display("FAIL abort_pre E%0d got %b want %b", k, got, exp_q[k]); end
            if (k < 14) begin @(posedge clk); #1; end
        end
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        got = get_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL abort_E15 got %b want %b", got, obs_t'('0)); end
        start_run(4'b1111, 1'b0);
        foreach (exp_q[k]) begin
            got = get_obs(); n_cmp++;
            if (got !== exp_q[k]) begin n_bad++; $display("FAIL abort_rerun E%0d got %b want %b", k, got, exp_q[k]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        obs_t got;
        int   len1;
        exp_q.delete(); push_run(4'b1111);
        start_run(4'b1111, 1'b1);
        for (int k = 0; k <= 4; k++) begin
            got = get_obs(); n_cmp++;
            if (got !== exp_q[k]) begin n_bad++; $display("FAIL midreset_pre E%0d got %b want %b", k, got, exp_q[k]); end
            @(posedge clk); #1;
        end
        // The edge that follows the E4 sample is already behind us; reset takes the next one.
        rst_n = 1'b0; bus.start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        got = get_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL midreset got %b want %b", got, obs_t'('0)); end
        @(posedge clk); #1;
        got = get_obs(); n_cmp++;
        if (got !== '0) begin n_bad++; $display("FAIL midreset_idle got %b want %b", got, obs_t'('0)); end

        exp_q.delete(); push_run(4'b1011);
        len1 = exp_q.size();
        push_run(4'b0110);
        bus.start = 1'b1; bus.load_mask = 4'b1011;
        @(posedge clk); #1;
        bus.load_mask = 4'b0110;
        foreach (exp_q[k]) begin
            got = get_obs(); n_cmp++;
            if (got !== exp_q[k]) begin n_bad++; $display("FAIL held_start E%0d got %b want %b", k, got, exp_q[k]); end
            if (k == len1) bus.start = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        obs_t       got;
        logic [3:0] mask;
        bit         hold;
        int         ab;
        for (int it = 0; it < 12; it++) begin
            mask = 4'($urandom_range(1, 15));
            hold = 1'($urandom_range(0, 1));
            exp_q.delete(); push_run(mask);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, exp_q.size() - 3)) : -1;
            start_run(mask, hold);
            for (int k = 0; k < exp_q.size(); k++) begin
                got = get_obs(); n_cmp++;
                if (got !== exp_q[k]) begin n_bad++; $display("FAIL random it%0d mask %b E%0d got %b want %b", it, mask, k, got, exp_q[k]); end
                if (k == exp_q.size() - 2) bus.start = 1'b0;
                if (k == ab - 1) begin
                    bus.start = 1'b0; bus.abort = 1'b1;
                    @(posedge clk); #1;
                    bus.abort = 1'b0;
                    got = get_obs(); n_cmp++;
                    if (got !== '0) begin n_bad++; $display("FAIL random_abort it%0d E%0d got %b want %b", it, ab, got, obs_t'('0)); end
                    break;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        bus.start = 1'b0; bus.abort = 1'b0; bus.load_mask = '0; rst_n = 1'b0;
        test_reset();
        test_full_mask();
        test_sparse_mask();
        test_zero_mask();
        test_abort();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
